// File: rtl/event_readout_serializer.sv
// -----------------------------------------------------------------------------
// event_readout_serializer
//
// Purpose:
//   On a readout request, pops a fixed number of sample sets from four channel
//   FIFOs (one shared read enable) and serializes them into a single 16-bit
//   valid/ready stream framed as header, sample words, trailer.
//
// Ports:
//   Clock, Reset         system clock, synchronous active-high reset
//   Start_Readout        single-cycle request, sampled only in IDLE
//   Sample_Count         samples per channel, latched with Start_Readout
//   Fifo_Q_0..Fifo_Q_3   FIFO read data, valid one cycle after Fifo_RE
//   Fifo_Empty           per-channel empty flags (bit n = channel n)
//   Fifo_RE              shared read enable to all channel FIFOs
//   Out_Data/Out_Valid   registered output word and its valid
//   Out_Ready            downstream accept
//   Out_Last             marks the trailer word
//   Busy                 high whenever the FSM is not in IDLE
//   Event_Counter        completed events, wraps at 12 bits
//   Underflow_Flag       sticky, set when a FIFO is empty at fetch time
//
// Optional feature:
//   READOUT_CHECKSUM_EN  when defined, a running XOR of all transferred sample
//                        words is emitted as an extra word before the trailer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for Start_Readout
// HEADER   | presenting {4'hE, Event_Counter}
// FETCH    | one cycle: pop all FIFOs, or flag underflow and finish
// CAPTURE  | one cycle: register FIFO data into the holding buffer
// SEND     | presenting holding words ch0..ch3
// CHECKSUM | presenting the XOR of sent sample words (optional build)
// TRAILER  | presenting {4'hF, err, Sent} with Out_Last
// -----------------------------------------------------------------------------
module event_readout_serializer #(
    parameter int g_Data_Width   = 16,
    parameter int g_Count_Length = 11,
    parameter int g_Num_Channels = 4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start_Readout,
    input  logic [g_Count_Length-1:0] Sample_Count,
    input  logic [g_Data_Width-1:0]   Fifo_Q_0,
    input  logic [g_Data_Width-1:0]   Fifo_Q_1,
    input  logic [g_Data_Width-1:0]   Fifo_Q_2,
    input  logic [g_Data_Width-1:0]   Fifo_Q_3,
    input  logic [g_Num_Channels-1:0] Fifo_Empty,
    output logic                      Fifo_RE,
    output logic [g_Data_Width-1:0]   Out_Data,
    output logic                      Out_Valid,
    input  logic                      Out_Ready,
    output logic                      Out_Last,
    output logic                      Busy,
    output logic [11:0]               Event_Counter,
    output logic                      Underflow_Flag
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HEADER   = 3'd1;
    localparam logic [2:0] S_FETCH    = 3'd2;
    localparam logic [2:0] S_CAPTURE  = 3'd3;
    localparam logic [2:0] S_SEND     = 3'd4;
    localparam logic [2:0] S_TRAILER  = 3'd5;
`ifdef READOUT_CHECKSUM_EN
    localparam logic [2:0] S_CHECKSUM = 3'd6;
`endif

    logic [2:0]                state;
    logic [g_Count_Length-1:0] remaining;
    logic [g_Count_Length-1:0] sent;
    logic                      err;
    logic [1:0]                idx;
    logic [g_Data_Width-1:0]   hold [g_Num_Channels];

    logic                      xfer;
    logic                      fetch_underflow;
    logic [g_Data_Width-1:0]   trailer_word;
    logic [g_Data_Width-1:0]   end_word;
    logic                      end_last;
    logic [2:0]                end_state;

`ifdef READOUT_CHECKSUM_EN
    logic [g_Data_Width-1:0]   csum;
`endif

    assign xfer            = Out_Valid & Out_Ready;
    assign fetch_underflow = (state == S_FETCH) && (Fifo_Empty != '0);
    // Reset gates the read enable so an abort never pops a FIFO.
    assign Fifo_RE         = (state == S_FETCH) && (Fifo_Empty == '0) && !Reset;
    assign Busy            = (state != S_IDLE);

    // err is only updated in FETCH, so fold in the underflow being detected
    // this cycle to get the trailer right when jumping straight to the end.
    assign trailer_word = {4'hF, err | fetch_underflow, sent};

    // Word, Out_Last and next state used on every path that ends the sample
    // phase (header with zero count, last SEND beat, underflow in FETCH).
    always_comb begin
`ifdef READOUT_CHECKSUM_EN
        // The last sample beat is transferring now; include it in the XOR.
        end_word  = (state == S_SEND) ? (csum ^ Out_Data) : csum;
        end_last  = 1'b0;
        end_state = S_CHECKSUM;
`else
        end_word  = trailer_word;
        end_last  = 1'b1;
        end_state = S_TRAILER;
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= S_IDLE;
            remaining      <= '0;
            sent           <= '0;
            err            <= 1'b0;
            idx            <= '0;
            Out_Data       <= '0;
            Out_Valid      <= 1'b0;
            Out_Last       <= 1'b0;
            Event_Counter  <= '0;
            Underflow_Flag <= 1'b0;
            for (int i = 0; i < g_Num_Channels; i++) begin
                hold[i] <= '0;
            end
`ifdef READOUT_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start_Readout) begin
                        remaining <= Sample_Count;
                        sent      <= '0;
                        err       <= 1'b0;
                        Out_Data  <= {4'hE, Event_Counter};
                        Out_Valid <= 1'b1;
                        Out_Last  <= 1'b0;
                        state     <= S_HEADER;
`ifdef READOUT_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end

                S_HEADER: begin
                    if (xfer) begin
                        if (remaining == '0) begin
                            Out_Data <= end_word;
                            Out_Last <= end_last;
                            state    <= end_state;
                        end else begin
                            Out_Valid <= 1'b0;
                            state     <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    if (fetch_underflow) begin
                        Underflow_Flag <= 1'b1;
                        err            <= 1'b1;
                        Out_Data       <= end_word;
                        Out_Last       <= end_last;
                        Out_Valid      <= 1'b1;
                        state          <= end_state;
                    end else begin
                        state <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    hold[0]   <= Fifo_Q_0;
                    hold[1]   <= Fifo_Q_1;
                    hold[2]   <= Fifo_Q_2;
                    hold[3]   <= Fifo_Q_3;
                    Out_Data  <= Fifo_Q_0;
                    Out_Valid <= 1'b1;
                    idx       <= '0;
                    remaining <= remaining - 1'b1;
                    sent      <= sent + 1'b1;
                    state     <= S_SEND;
                end

                S_SEND: begin
                    if (xfer) begin
`ifdef READOUT_CHECKSUM_EN
                        csum <= csum ^ Out_Data;
`endif
                        if (idx == 2'd3) begin
                            if (remaining == '0) begin
                                Out_Data <= end_word;
                                Out_Last <= end_last;
                                state    <= end_state;
                            end else begin
                                Out_Valid <= 1'b0;
                                state     <= S_FETCH;
                            end
                        end else begin
                            idx      <= idx + 2'd1;
                            Out_Data <= hold[idx + 2'd1];
                        end
                    end
                end

`ifdef READOUT_CHECKSUM_EN
                S_CHECKSUM: begin
                    if (xfer) begin
                        Out_Data <= trailer_word;
                        Out_Last <= 1'b1;
                        state    <= S_TRAILER;
                    end
                end
`endif

                S_TRAILER: begin
                    if (xfer) begin
                        Out_Valid     <= 1'b0;
                        Out_Last      <= 1'b0;
                        Event_Counter <= Event_Counter + 12'd1;
                        state         <= S_IDLE;
                    end
                end

                default: begin
                    Out_Valid <= 1'b0;
                    Out_Last  <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/event_readout_serializer.md
Name: event_readout_serializer

Overview:
- Downstream of the four-channel trigger/FIFO input stage.
- On a readout request, pops a fixed number of samples from the four channel FIFOs in lockstep using one shared read enable.
- Serializes each sample set into a single 16-bit valid/ready stream, framed as header, sample words and trailer.
- Feeds the communication/readout path.

Parameters:
- g_Data_Width, 16, width of each FIFO word and of the output word.
- g_Count_Length, 11, width of Sample_Count and of the trailer sample-count field.
- g_Num_Channels, 4, number of channel FIFOs read in lockstep. Fixed at 4 in this revision.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous reset, active-high.
- Start_Readout  in  1  single-cycle request; sampled only in IDLE.
- Sample_Count  in  11  samples per channel for this event; latched with Start_Readout.
- Fifo_Q_0..Fifo_Q_3  in  16 each  FIFO read data; valid exactly 1 cycle after Fifo_RE.
- Fifo_Empty  in  4  per-channel FIFO empty flags, bit n = channel n.
- Fifo_RE  out  1  shared read enable to all four FIFOs.
- Out_Data  out  16  serialized output word.
- Out_Valid  out  1  Out_Data valid.
- Out_Ready  in  1  downstream accept.
- Out_Last  out  1  marks the trailer word.
- Busy  out  1  high in every state except IDLE.
- Event_Counter  out  12  number of completed events.
- Underflow_Flag  out  1  sticky; cleared only by Reset.

Behaviour:
- Interface: one clock (Clock); synchronous active-high reset (Reset).
- Reset state: all outputs 0, FSM in IDLE, Event_Counter 0. Reset mid-event aborts immediately: no further Fifo_RE, no trailer emitted.
- Handshake: a beat transfers when Out_Valid & Out_Ready. While Out_Valid=1 and Out_Ready=0, Out_Data and Out_Last hold stable. Out_Valid never drops without a transfer.
- IDLE:
  - Start_Readout=1 latches Sample_Count into Remaining, clears Sent, goes to HEADER.
  - Start_Readout is ignored in every other state.
- HEADER:
  - Drives {4'hE, Event_Counter}.
  - On transfer: Remaining=0 goes to TRAILER; otherwise goes to FETCH.
- FETCH (1 cycle):
  - If Fifo_Empty=0000: Fifo_RE=1, go to CAPTURE.
  - If any Fifo_Empty bit is 1: Fifo_RE stays 0, set Underflow_Flag and the event's err bit, go to TRAILER.
- CAPTURE (1 cycle):
  - Registers Fifo_Q_0..3 into a 4-word holding buffer.
  - Decrements Remaining, increments Sent, goes to SEND with channel index 0.
- SEND:
  - Drives holding word[index], order ch0, ch1, ch2, ch3. Words pass through unchanged.
  - Index advances on each transfer. After the ch3 transfer: Remaining=0 goes to TRAILER (or CHECKSUM, see Optional Feature); otherwise goes to FETCH.
- TRAILER:
  - Drives {4'hF, err, Sent[10:0]} with Out_Last=1.
  - On transfer: Event_Counter increments (wraps 0xFFF→0x000), go to IDLE.
- Fifo_RE is asserted at most once per sample set. Never asserted outside FETCH.
- Best-case timing: 6 cycles per sample set (4 output beats). Event length = 2 + 4·N beats.
- Sample_Count=0 emits header + trailer only, no Fifo_RE.
- Output is registered; Out_Valid first rises the cycle after Start_Readout is accepted.

Optional Feature:
- Macro: READOUT_CHECKSUM_EN.
- Defined:
  - A 16-bit running XOR of every transferred sample word (not header or trailer), cleared in HEADER.
  - State CHECKSUM, inserted before TRAILER on every exit path including underflow, emits the XOR word. Out_Last=0 on this word.
  - Event length becomes 3 + 4·N beats.
- Undefined: no CHECKSUM state, no accumulator logic.

Test Plan:
- Reset check: Reset held 3 cycles mid-SEND → Out_Valid=0, Fifo_RE=0, Busy=0, Event_Counter=0; a new Start_Readout then yields header 0xE000.
- Single sample: Sample_Count=1, Fifo_Q_0..3=0x1111/0x2222/0x3333/0x4444, Out_Ready=1 → beats E000, 1111, 2222, 3333, 4444, F001 with Out_Last on F001; exactly one Fifo_RE pulse; Event_Counter=1.
- Backpressure: Sample_Count=2, Out_Ready toggled 1/0 each cycle → same 10-word sequence, data stable during stalls, 2 Fifo_RE pulses total.
- Underflow: Sample_Count=3, Fifo_Empty[2] rises after 1 sample → E000, 4 sample words, trailer F801 (err=1, Sent=1); Underflow_Flag stays 1 after the event.
- Zero count and wrap: Sample_Count=0 → E000, F000, no Fifo_RE. Preload Event_Counter to 0xFFF via 4095 events → header EFFF, then counter reads 0x000.
- Checksum build (READOUT_CHECKSUM_EN): Sample_Count=1 with words above → extra word 0x4444 (1111^2222^3333^4444) before trailer F001; ignored Start_Readout during Busy produces no second header.
